// File: rtl/fanout_fork_ctrl.sv
// ---------------------------------------------------------------------------
// fanout_fork_ctrl
//
// Eager-fork controller: broadcasts one ready/valid input stream to NUM_OUT
// downstream ports. Each destination may accept the current token on its own
// cycle. A per-output "done" bit remembers who already took the token, and
// the input is released only once every active destination has taken it.
//
// Ports:
//   clk           clock
//   rst           synchronous reset, active-high
//   cfg_en_mask   per-output enable (held static while busy)
//   cfg_sel_mask  per-output route select (held static while busy)
//   flush         synchronous clear of fork progress
//   in_data       upstream token
//   in_valid      upstream valid
//   in_ready      upstream ready
//   out_data      broadcast token shared by all outputs
//   out_valid     per-output valid
//   out_ready     per-output ready
//   busy          token partially delivered
//   tok_count     saturating count of input tokens consumed since reset
// ---------------------------------------------------------------------------
module fanout_fork_ctrl #(
    parameter int NUM_OUT = 9,
    parameter int DATA_W  = 17,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_OUT-1:0] cfg_en_mask,
    input  logic [NUM_OUT-1:0] cfg_sel_mask,
    input  logic               flush,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   tok_count
);

    logic [NUM_OUT-1:0] active;
    logic [NUM_OUT-1:0] take;
    logic [NUM_OUT-1:0] slot_ok;
    logic [NUM_OUT-1:0] done_reg;
    logic [NUM_OUT-1:0] done_next;
    logic [CNT_W-1:0]   tok_count_reg;
    logic [CNT_W-1:0]   tok_count_next;
    logic               xfer;

    assign active   = cfg_en_mask & cfg_sel_mask;
    assign out_data = in_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
            // An output is offered the token only until it has taken it once.
            assign out_valid[gi] = in_valid & active[gi] & ~done_reg[gi] & ~flush;
            assign take[gi]      = out_valid[gi] & out_ready[gi];
            // An output no longer holds up the input if it is inactive,
            // already served, or accepting right now. Done bits of outputs
            // outside the active set are masked by the ~active term.
            assign slot_ok[gi]   = ~active[gi] | done_reg[gi] | out_ready[gi];
        end
    endgenerate

    // Combinational out_ready -> in_ready path gives zero-cycle forwarding
    // when all active outputs are ready together. An empty active set
    // makes every slot_ok bit 1, so the token is simply sunk.
    assign in_ready = ~flush & (&slot_ok);
    assign xfer     = in_valid & in_ready;

    always_comb begin
        done_next = done_reg | take;
        if (flush || xfer) begin
            done_next = '0;
        end
    end

    always_comb begin
        tok_count_next = tok_count_reg;
        if (xfer && (tok_count_reg != {CNT_W{1'b1}})) begin
            tok_count_next = tok_count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_reg      <= '0;
            tok_count_reg <= '0;
        end else begin
            done_reg      <= done_next;
            tok_count_reg <= tok_count_next;
        end
    end

    assign busy      = |done_reg;
    assign tok_count = tok_count_reg;

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fanout_fork_ctrl
//
// Directed bench for fanout_fork_ctrl. A second instance with CNT_W=4 shares
// all inputs so the saturating counter can be exercised in a few cycles.
// Inputs are changed 1 time unit after the rising edge and outputs are
// sampled a further 1 time unit later, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_fanout_fork_ctrl;

    localparam int NUM_OUT = 9;
    localparam int DATA_W  = 17;
    localparam int CNT_W   = 16;

    logic               clk;
    logic               rst;
    logic [NUM_OUT-1:0] cfg_en_mask;
    logic [NUM_OUT-1:0] cfg_sel_mask;
    logic               flush;
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  out_data;
    logic [NUM_OUT-1:0] out_valid;
    logic [NUM_OUT-1:0] out_ready;
    logic               busy;
    logic [CNT_W-1:0]   tok_count;

    logic               s_in_ready;
    logic [DATA_W-1:0]  s_out_data;
    logic [NUM_OUT-1:0] s_out_valid;
    logic               s_busy;
    logic [3:0]         s_tok_count;

    int checks = 0;
    int errors = 0;

    fanout_fork_ctrl #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_en_mask(cfg_en_mask), .cfg_sel_mask(cfg_sel_mask),
        .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .tok_count(tok_count)
    );

    fanout_fork_ctrl #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst),
        .cfg_en_mask(cfg_en_mask), .cfg_sel_mask(cfg_sel_mask),
        .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .busy(s_busy), .tok_count(s_tok_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; return 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_en_mask = 9'h1FF; cfg_sel_mask = 9'h1FF; flush = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = '0;
        step(); step();
        settle();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (tok_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", tok_count); end
        checks++;
        if (out_valid !== 9'h000) begin errors++; $display("FAIL reset_valid: got %h want 000", out_valid); end
        // All outputs active but none ready: input must be held off.
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        $display("test_reset: busy=%b tok_count=%0d out_valid=%h in_ready=%b", busy, tok_count, out_valid, in_ready);
        rst = 1'b0;
        step();
    endtask

    task automatic test_all_ready();
        cfg_sel_mask = 9'h1FF; out_ready = 9'h1FF; in_valid = 1'b1; in_data = 17'h000A5;
        settle();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL all_in_ready: got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 9'h1FF) begin errors++; $display("FAIL all_valid: got %h want 1ff", out_valid); end
        checks++;
        if (out_data !== 17'h000A5) begin errors++; $display("FAIL all_data: got %h want 000a5", out_data); end
        step();
        in_valid = 1'b0; out_ready = '0;
        settle();
        checks++;
        if (tok_count !== 16'd1) begin errors++; $display("FAIL all_count: got %0d want 1", tok_count); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL all_busy: got %b want 0", busy); end
        $display("test_all_ready: tok_count=%0d busy=%b", tok_count, busy);
    endtask

    task automatic test_stagger();
        // Enable all, select outputs 0..2 only: active set 0x007.
        cfg_sel_mask = 9'h007; in_valid = 1'b1; in_data = 17'h01234; out_ready = 9'h001;
        settle();
        checks++;
        if (out_valid !== 9'h007) begin errors++; $display("FAIL stag_c0_valid: got %h want 007", out_valid); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stag_c0_ready: got %b want 0", in_ready); end
        step();
        out_ready = 9'h002;
        settle();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL stag_c1_busy: got %b want 1", busy); end
        checks++;
        if (out_valid !== 9'h006) begin errors++; $display("FAIL stag_c1_valid: got %h want 006", out_valid); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stag_c1_ready: got %b want 0", in_ready); end
        step();
        out_ready = 9'h004;
        settle();
        checks++;
        if (out_valid !== 9'h004) begin errors++; $display("FAIL stag_c2_valid: got %h want 004", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stag_c2_ready: got %b want 1", in_ready); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL stag_c2_busy: got %b want 1", busy); end
        step();
        in_valid = 1'b0; out_ready = '0;
        settle();
        checks++;
        if (tok_count !== 16'd2) begin errors++; $display("FAIL stag_count: got %0d want 2", tok_count); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL stag_busy_end: got %b want 0", busy); end
        $display("test_stagger: tok_count=%0d busy=%b", tok_count, busy);
    endtask

    task automatic test_sink();
        cfg_sel_mask = 9'h000; in_valid = 1'b1; out_ready = '0;
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL sink_ready[%0d]: got %b want 1", i, in_ready); end
            checks++;
            if (out_valid !== 9'h000) begin errors++; $display("FAIL sink_valid[%0d]: got %h want 000", i, out_valid); end
            step();
        end
        in_valid = 1'b0;
        settle();
        checks++;
        if (tok_count !== 16'd7) begin errors++; $display("FAIL sink_count: got %0d want 7", tok_count); end
        $display("test_sink: tok_count=%0d", tok_count);
    endtask

    task automatic test_flush();
        cfg_sel_mask = 9'h003; in_valid = 1'b1; in_data = 17'h10055; out_ready = 9'h001;
        step();
        out_ready = '0; flush = 1'b1;
        settle();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_pre: got %b want 1", busy); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        checks++;
        if (out_valid !== 9'h000) begin errors++; $display("FAIL flush_valid: got %h want 000", out_valid); end
        step();
        flush = 1'b0;
        settle();
        checks++;
        if (out_valid !== 9'h003) begin errors++; $display("FAIL flush_revalid: got %h want 003", out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_post: got %b want 0", busy); end
        checks++;
        if (tok_count !== 16'd7) begin errors++; $display("FAIL flush_count: got %0d want 7", tok_count); end
        // Complete the re-offered token.
        out_ready = 9'h003;
        step();
        in_valid = 1'b0; out_ready = '0;
        settle();
        checks++;
        if (tok_count !== 16'd8) begin errors++; $display("FAIL flush_count_done: got %0d want 8", tok_count); end
        $display("test_flush: tok_count=%0d", tok_count);
    endtask

    task automatic test_reset_mid();
        cfg_sel_mask = 9'h1FF; in_valid = 1'b1; in_data = 17'h00F0F; out_ready = 9'h010;
        step();
        out_ready = '0;
        settle();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre: got %b want 1", busy); end
        checks++;
        if (out_valid !== 9'h1EF) begin errors++; $display("FAIL rmid_valid_pre: got %h want 1ef", out_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++;
        if (tok_count !== 16'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", tok_count); end
        checks++;
        if (out_valid !== 9'h1FF) begin errors++; $display("FAIL rmid_valid: got %h want 1ff", out_valid); end
        in_valid = 1'b0;
        $display("test_reset_mid: busy=%b tok_count=%0d out_valid=%h", busy, tok_count, out_valid);
    endtask

    task automatic test_saturation();
        int exp_small;
        cfg_sel_mask = 9'h000; in_valid = 1'b1; out_ready = '0;
        for (int i = 1; i <= 20; i++) begin
            step();
            exp_small = (i > 15) ? 15 : i;
            checks++;
            if (s_tok_count !== 4'(exp_small)) begin
                errors++; $display("FAIL sat_small[%0d]: got %0d want %0d", i, s_tok_count, exp_small);
            end
        end
        in_valid = 1'b0;
        settle();
        checks++;
        if (tok_count !== 16'd20) begin errors++; $display("FAIL sat_main: got %0d want 20", tok_count); end
        $display("test_saturation: small=%0d main=%0d", s_tok_count, tok_count);
    endtask

    task automatic test_back_to_back();
        cfg_sel_mask = 9'h1FF; out_ready = 9'h1FF; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 17'(i + 17'h100);
            settle();
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
            step();
        end
        in_valid = 1'b0; out_ready = '0;
        settle();
        checks++;
        if (tok_count !== 16'd23) begin errors++; $display("FAIL b2b_count: got %0d want 23", tok_count); end
        checks++;
        if (s_tok_count !== 4'd15) begin errors++; $display("FAIL b2b_small: got %0d want 15", s_tok_count); end
        $display("test_back_to_back: tok_count=%0d small=%0d", tok_count, s_tok_count);
    endtask

    initial begin
        test_reset();
        test_all_ready();
        test_stagger();
        test_sink();
        test_flush();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
